// File: rtl/full_adder.sv
// Ripple-carry full adder: {C, S} = a + b + c, one 1-bit cell per operand bit.
// Latency: zero cycles when REGISTERED=0, one clk cycle when REGISTERED=1.
// Backpressure: none; new operands are accepted every cycle and outputs never stall.

// 1-bit full-adder cell: the leaf of the ripple chain.
// Latency: purely combinational.
// Backpressure: none.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is odd parity of the three inputs; carry is their majority.
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module full_adder #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned REGISTERED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    // k[i] is the carry into bit i; k[WIDTH] is the carry-out of the MSB.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] s;

    assign k[0] = c;

    // One cell per bit, carries rippling LSB to MSB; kept as a plain ripple on purpose.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (k[i]),
            .s  (s[i]),
            .co (k[i+1])
        );
    end

    if (REGISTERED != 0) begin : g_reg
        // Result flops load every edge; reset clears them immediately and discards any pending sum.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                S <= '0;
                C <= 1'b0;
            end else begin
                S <= s;
                C <= k[WIDTH];
            end
        end
    end else begin : g_comb
        // Combinational mode drives the ripple result straight out; clk/rst are intentionally ignored.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign S = s;
        assign C = k[WIDTH];
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder in combinational and registered builds.
// Latency: bench only.
// Backpressure: not applicable.
module tb_full_adder;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH=1 combinational instance
    logic       a1, b1, c1;
    logic       s1, co1;
    // WIDTH=4 combinational instance
    logic [3:0] a4, b4;
    logic       c4;
    logic [3:0] s4;
    logic       co4;
    // WIDTH=4 registered instance
    logic [3:0] ar, br;
    logic       cr;
    logic [3:0] sr;
    logic       cor;
    // WIDTH=8 combinational instance
    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] s8;
    logic       co8;

    full_adder #(.WIDTH(1), .REGISTERED(0)) u_w1 (
        .clk (1'b0), .rst (1'b0), .a (a1), .b (b1), .c (c1), .S (s1), .C (co1)
    );
    full_adder #(.WIDTH(4), .REGISTERED(0)) u_w4 (
        .clk (1'b0), .rst (1'b0), .a (a4), .b (b4), .c (c4), .S (s4), .C (co4)
    );
    full_adder #(.WIDTH(4), .REGISTERED(1)) u_w4r (
        .clk (clk), .rst (rst), .a (ar), .b (br), .c (cr), .S (sr), .C (cor)
    );
    full_adder #(.WIDTH(8), .REGISTERED(0)) u_w8 (
        .clk (1'b0), .rst (1'b0), .a (a8), .b (b8), .c (c8), .S (s8), .C (co8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Hand-written truth table, indexed by {a,b,c}; each entry is {S,C}.
    logic [1:0] tt [8];
    logic [8:0] exp9;

    initial begin
        tt[0] = 2'b00; tt[1] = 2'b10; tt[2] = 2'b10; tt[3] = 2'b01;
        tt[4] = 2'b10; tt[5] = 2'b01; tt[6] = 2'b01; tt[7] = 2'b11;

        a1 = 0; b1 = 0; c1 = 0;
        a4 = 0; b4 = 0; c4 = 0;
        ar = 0; br = 0; cr = 0;
        a8 = 0; b8 = 0; c8 = 0;

        // WIDTH=1 truth table at 5-unit spacing, then back to 000
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            #5;
            check($sformatf("w1_S_%0d", i), 32'(s1), 32'(tt[i][1]));
            check($sformatf("w1_C_%0d", i), 32'(co1), 32'(tt[i][0]));
        end
        {a1, b1, c1} = 3'b000;
        #5;
        check("w1_S_back0", 32'(s1), 32'd0);
        check("w1_C_back0", 32'(co1), 32'd0);

        // WIDTH=4 combinational directed vectors
        a4 = 4'd15; b4 = 4'd0; c4 = 1'b1; #5;
        check("w4_wrap", 32'({co4, s4}), 32'h10);
        a4 = 4'd15; b4 = 4'd15; c4 = 1'b1; #5;
        check("w4_max", 32'({co4, s4}), 32'h1F);
        a4 = 4'd5; b4 = 4'd6; c4 = 1'b0; #5;
        check("w4_5p6", 32'({co4, s4}), 32'h0B);

        // WIDTH=4 registered: reset state while rst held
        @(negedge clk);
        check("r_reset_S", 32'(sr), 32'd0);
        check("r_reset_C", 32'(cor), 32'd0);

        // Release reset and present 3+4+1 before the next edge
        rst = 1'b0;
        ar = 4'd3; br = 4'd4; cr = 1'b1;
        #2;
        check("r_pre_edge", 32'({cor, sr}), 32'h00);
        @(posedge clk); #1;
        check("r_load_3p4p1", 32'({cor, sr}), 32'h08);

        // Mid-cycle toggle must not disturb outputs
        ar = 4'd1; br = 4'd1; cr = 1'b0;
        #2;
        check("r_hold_mid", 32'({cor, sr}), 32'h08);
        @(posedge clk); #1;
        check("r_load_1p1", 32'({cor, sr}), 32'h02);

        // Load S=9, C=1 (15+9+1=25)
        ar = 4'd15; br = 4'd9; cr = 1'b1;
        @(posedge clk); #1;
        check("r_load_25", 32'({cor, sr}), 32'h19);

        // Async reset between edges clears immediately
        #2;
        rst = 1'b1;
        #1;
        check("r_async_rst", 32'({cor, sr}), 32'h00);
        ar = 4'd2; br = 4'd3; cr = 1'b0;
        @(posedge clk); #1;
        check("r_rst_edge1", 32'({cor, sr}), 32'h00);
        @(posedge clk); #1;
        check("r_rst_edge2", 32'({cor, sr}), 32'h00);

        // Release between edges; first edge loads 2+3
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("r_released_pre", 32'({cor, sr}), 32'h00);
        @(posedge clk); #1;
        check("r_first_load", 32'({cor, sr}), 32'h05);

        // WIDTH=8 random vectors against the arithmetic sum
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom_range(255));
            b8 = 8'($urandom_range(255));
            c8 = 1'($urandom_range(1));
            exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
            #5;
            check($sformatf("w8_rand_%0d", i), 32'({co8, s8}), 32'(exp9));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
